reduction_accumulator: RTL
==========================

# reduction_accumulator

Downstream of the combinational adder-tree reduction stage. Accepts one tree sum per beat over a valid/ready handshake and accumulates a programmed number of beats into a wide register. It presents the final total to the consumer with a valid/ready handshake. Partial dot-products wider than the tree's NUM_MOD lanes are completed here before write-back.

## Interface
Parameters:
- WIDTH_IN, 37, width of incoming tree sum (tree WIDTH + clog2(NUM_MOD)), unsigned
- WIDTH_ACC, 48, accumulator and result width
- WIDTH_CNT, 16, beat-count width

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; one clock, reset is asynchronous and active-high
- I_Start  in  1  begin a reduction; sampled only in IDLE
- I_Num  in  WIDTH_CNT  beats to accumulate, sampled with I_Start
- I_Valid  in  1  upstream sum valid
- I_Val  in  WIDTH_IN  upstream tree sum (adder-tree output)
- O_Ready  out  1  beat accepted when I_Valid & O_Ready
- O_Valid  out  1  final result valid
- O_Acc  out  WIDTH_ACC  final result
- I_Ready  in  1  consumer accepts result when O_Valid & I_Ready
- O_Busy  out  1  high in ACCUM and DONE
- O_Overflow  out  1  carry-out occurred during current/last reduction (sticky per reduction)

## Operation
- FSM states: IDLE, ACCUM, DONE (registered state, one-hot or binary at implementer's choice).
- IDLE: O_Ready=0, O_Valid=0. On I_Start: acc<=0, overflow<=0, remain<=I_Num; next state ACCUM if I_Num!=0, else DONE with O_Acc=0.
- ACCUM: O_Ready=1 (combinational decode of state). Per accepted beat: acc <= acc + zero-extend(I_Val) modulo 2^WIDTH_ACC; carry out of bit WIDTH_ACC-1 sets overflow; remain<=remain-1. Beat with remain==1 is the last: next state DONE.
- Cycles with I_Valid=0 in ACCUM: no change (bubbles allowed, unlimited).
- DONE: O_Valid=1, O_Acc=acc, O_Ready=0. On I_Ready: next state IDLE, O_Valid drops next cycle.
- I_Start outside IDLE ignored; I_Valid outside ACCUM ignored (not consumed, O_Ready=0).
- O_Acc and O_Overflow hold their values from DONE through IDLE until the next I_Start clears them.
- Arithmetic unsigned only; no saturation, wrap with O_Overflow flag.
- WIDTH_ACC >= WIDTH_IN required (elaboration-time check).

## Timing
- Reset (async assert, sync-safe deassert handled externally): state=IDLE, acc=0, remain=0, O_Valid=0, O_Ready=0, O_Busy=0, O_Overflow=0, O_Acc=0.
- Start latency: I_Start at cycle t -> O_Ready=1 at t+1.
- Result latency: last beat accepted at cycle t -> O_Valid=1 with final O_Acc at t+1.
- Minimum reduction of N beats with no bubbles: 1 (start) + N + 1 (handoff) cycles; N=0: O_Valid at t+1 after I_Start.
- O_Valid, O_Acc stable while O_Valid & !I_Ready (no retraction).
- Handoff and new I_Start cannot share a cycle: I_Start earliest one cycle after I_Ready accepted (back in IDLE).
- Reset mid-reduction: immediately to reset values; partial sum discarded; no O_Valid emitted.
- remain never underflows: DONE entered exactly on remain 1->0.

## Test plan
- Basic: I_Num=4, beats 10,20,30,40 back-to-back, I_Ready=1 -> O_Valid one cycle after 4th beat, O_Acc=100, O_Overflow=0, IDLE next cycle.
- Bubbles/backpressure: I_Num=3, beats 5,(idle 2 cycles),7,9, I_Ready held 0 for 5 cycles -> O_Acc=21 held stable with O_Valid=1 throughout, released on I_Ready.
- Zero count: I_Start with I_Num=0 -> O_Valid next cycle, O_Acc=0, no beats consumed (O_Ready stays 0).
- Overflow: WIDTH_IN=37, WIDTH_ACC=38, I_Num=3, I_Val=2^37-1 each -> O_Acc=(3*(2^37-1)) mod 2^38, O_Overflow=1; next reduction of 1 beat of 1 -> O_Overflow=0, O_Acc=1.
- Ignored inputs: I_Valid pulsed in IDLE and DONE, I_Start pulsed in ACCUM -> no state/acc change, count unaffected, result matches beats accepted in ACCUM only.
- Reset mid-op: assert reset after 2 of 5 beats -> all outputs at reset values within same cycle (async); new I_Num=1, beat 9 -> O_Acc=9.

Source files
------------

// File: rtl/reduction_accumulator_if.sv
// Handshake bundle between the adder-tree reduction stage, the accumulator
// and the result consumer.
interface reduction_accumulator_if #(
    parameter int WIDTH_IN  = 37,
    parameter int WIDTH_ACC = 48,
    parameter int WIDTH_CNT = 16
);
    logic                 I_Start;
    logic [WIDTH_CNT-1:0] I_Num;
    logic                 I_Valid;
    logic [WIDTH_IN-1:0]  I_Val;
    logic                 O_Ready;
    logic                 O_Valid;
    logic [WIDTH_ACC-1:0] O_Acc;
    logic                 I_Ready;
    logic                 O_Busy;
    logic                 O_Overflow;

    // Producer/consumer side (drives starts, beats and result acceptance)
    modport master (
        output I_Start, I_Num, I_Valid, I_Val, I_Ready,
        input  O_Ready, O_Valid, O_Acc, O_Busy, O_Overflow
    );

    // Accumulator side
    modport slave (
        input  I_Start, I_Num, I_Valid, I_Val, I_Ready,
        output O_Ready, O_Valid, O_Acc, O_Busy, O_Overflow
    );
endinterface

// File: rtl/reduction_accumulator.sv
// Accumulates a programmed number of adder-tree sums into a wide register and
// hands the total to the consumer over a valid/ready handshake. Wraps modulo
// 2^WIDTH_ACC and reports any carry-out as a sticky per-reduction flag.
module reduction_accumulator #(
    parameter int WIDTH_IN  = 37,
    parameter int WIDTH_ACC = 48,
    parameter int WIDTH_CNT = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    reduction_accumulator_if.slave bus
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    if (WIDTH_ACC < WIDTH_IN) begin : g_width_check
        $error("reduction_accumulator: WIDTH_ACC must be >= WIDTH_IN");
    end

    logic [1:0]           state;
    logic [WIDTH_ACC-1:0] acc;
    logic [WIDTH_CNT-1:0] remain;
    logic                 overflow;
    logic [WIDTH_ACC:0]   acc_sum;

    // Unsigned add of a zero-extended tree sum; the top bit is the carry out.
    function automatic logic [WIDTH_ACC:0] acc_add(
        input logic [WIDTH_ACC-1:0] a,
        input logic [WIDTH_IN-1:0]  b
    );
        logic [WIDTH_ACC:0] b_ext;
        b_ext = {{(WIDTH_ACC + 1 - WIDTH_IN){1'b0}}, b};
        return {1'b0, a} + b_ext;
    endfunction

    // Candidate next accumulator value for the beat currently offered.
    always_comb begin
        acc_sum = acc_add(acc, bus.I_Val);
    end

    assign bus.O_Ready    = (state == ACCUM);
    assign bus.O_Valid    = (state == DONE);
    assign bus.O_Busy     = (state != IDLE);
    assign bus.O_Acc      = acc;
    assign bus.O_Overflow = overflow;

    // Reduction control: load count on start, sum beats, hold result until taken.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            acc      <= '0;
            remain   <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.I_Start) begin
                        acc      <= '0;
                        overflow <= 1'b0;
                        remain   <= bus.I_Num;
                        state    <= (bus.I_Num != '0) ? ACCUM : DONE;
                    end
                end
                ACCUM: begin
                    if (bus.I_Valid) begin
                        acc    <= acc_sum[WIDTH_ACC-1:0];
                        remain <= remain - 1'b1;
                        if (acc_sum[WIDTH_ACC]) begin
                            overflow <= 1'b1;
                        end
                        // remain is nonzero here, so the last beat is remain==1
                        if (remain == {{(WIDTH_CNT-1){1'b0}}, 1'b1}) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (bus.I_Ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
